fifo_access_ctrl: RTL and testbench

//  Button/switch front-end that sequences single-word pushes and pops on synchronous_fifo.
//  - Debounces the write/read push-buttons and arbitrates between them.
//  - Issues one-cycle wr/rd strobes and tracks occupancy.
//  - Holds the last written and last read bytes for the BCD_Control/ssd_driver display path.

---
 rtl/fifo_access_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: push-button front-end for synchronous_fifo.
// Debounces the write/read buttons, arbitrates between them, issues one-cycle
// wr/rd strobes, tracks occupancy and keeps the last written/read bytes for
// the seven-segment display path.
//
// Handshake: a debounced rising edge raises a pending flag that stays up until
// the FSM consumes it in IDLE. A write is accepted only when fifo_full is low
// and a read only when fifo_empty is low. The matching strobe is high for
// exactly the one cycle after acceptance. Read data is taken RD_LAT cycles
// after the read strobe cycle.
module fifo_access_ctrl #(
   parameter int DEB_CYCLES = 250000,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 5,
   parameter int RD_LAT     = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_wr,
   input  logic             btn_rd,
   input  logic [7:0]       sw_data,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   input  logic [7:0]       fifo_data_out,
   output logic             fifo_wr,
   output logic             fifo_rd,
   output logic [7:0]       fifo_data_in,
   output logic [7:0]       last_wr_data,
   output logic [7:0]       last_rd_data,
   output logic [CNT_W-1:0] occupancy,
   output logic             busy,
   output logic             err_full,
   output logic             err_empty,
   output logic [1:0]       dbg_state
);

   localparam int   DBW      = $clog2(DEB_CYCLES) + 1;
   localparam logic LAT_LAST = (RD_LAT == 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WR    = 2'd1,
      S_RD    = 2'd2,
      S_RWAIT = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       w_btn;
   logic [1:0]       w_rise;
   logic             r_pend_wr;
   logic             r_pend_rd;
   logic             r_prio;       // 0: write wins a tie, 1: read wins
   logic             r_fifo_wr;
   logic             r_fifo_rd;
   logic [7:0]       r_data_in;
   logic [7:0]       r_last_wr;
   logic [7:0]       r_last_rd;
   logic [CNT_W-1:0] r_occ;
   logic             r_err_full;
   logic             r_err_empty;
   logic             r_lat_cnt;
   logic             w_serve_wr;
   logic             w_serve_rd;
   logic             w_acc_wr;
   logic             w_acc_rd;
   logic             w_ref_wr;
   logic             w_ref_rd;
   logic             w_tog;

   assign w_btn = {btn_rd, btn_wr};

   // Per-button synchronizer + debounce counter + rising-edge pulse.
   // The synchronizer resets to 1 so a button held through reset never looks
   // released; r_arm only opens once a released (low) level has been seen.
   for (genvar g = 0; g < 2; g++) begin : g_deb
      logic [1:0]     r_sync;
      logic [DBW-1:0] r_cnt;
      logic           r_db;
      logic           r_arm;
      logic           r_rise;

      // Count consecutive samples that disagree with the debounced level.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_arm  <= 1'b0;
            r_rise <= 1'b0;
         end else begin
            r_sync <= {r_sync[0], w_btn[g]};
            r_rise <= 1'b0;
            if (r_sync[1] != r_db) begin
               if (r_cnt == DBW'(DEB_CYCLES - 1)) begin
                  r_db   <= r_sync[1];
                  r_cnt  <= '0;
                  r_rise <= r_sync[1] & r_arm;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               r_cnt <= '0;
            end
            if (!r_sync[1] && !r_db) r_arm <= 1'b1;
         end
      end

      assign w_rise[g] = r_rise;
   end

   // Next-state and accept/refuse decisions.
   always_comb begin
      w_next     = r_state;
      w_serve_wr = 1'b0;
      w_serve_rd = 1'b0;
      w_acc_wr   = 1'b0;
      w_acc_rd   = 1'b0;
      w_ref_wr   = 1'b0;
      w_ref_rd   = 1'b0;
      w_tog      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pend_wr && r_pend_rd) begin
               w_tog = 1'b1;
               if (r_prio) w_serve_rd = 1'b1;
               else        w_serve_wr = 1'b1;
            end else if (r_pend_wr) begin
               w_serve_wr = 1'b1;
            end else if (r_pend_rd) begin
               w_serve_rd = 1'b1;
            end
            if (w_serve_wr) begin
               if (fifo_full) w_ref_wr = 1'b1;
               else begin
                  w_acc_wr = 1'b1;
                  w_next   = S_WR;
               end
            end
            if (w_serve_rd) begin
               if (fifo_empty) w_ref_rd = 1'b1;
               else begin
                  w_acc_rd = 1'b1;
                  w_next   = S_RD;
               end
            end
         end
         S_WR:    w_next = S_IDLE;
         S_RD:    w_next = S_RWAIT;
         S_RWAIT: if (r_lat_cnt == LAT_LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Strobes, pending flags, captured data, occupancy and error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fifo_wr   <= 1'b0;
         r_fifo_rd   <= 1'b0;
         r_pend_wr   <= 1'b0;
         r_pend_rd   <= 1'b0;
         r_prio      <= 1'b0;
         r_data_in   <= '0;
         r_last_wr   <= '0;
         r_last_rd   <= '0;
         r_occ       <= '0;
         r_err_full  <= 1'b0;
         r_err_empty <= 1'b0;
         r_lat_cnt   <= 1'b0;
      end else begin
         r_fifo_wr <= (w_next == S_WR);
         r_fifo_rd <= (w_next == S_RD);
         // A new edge wins over a same-cycle consume; extra edges are absorbed.
         r_pend_wr <= (r_pend_wr & ~(w_acc_wr | w_ref_wr)) | w_rise[0];
         r_pend_rd <= (r_pend_rd & ~(w_acc_rd | w_ref_rd)) | w_rise[1];
         if (w_tog)    r_prio      <= ~r_prio;
         if (w_acc_wr) r_data_in   <= sw_data;
         if (w_ref_wr) r_err_full  <= 1'b1;
         if (w_ref_rd) r_err_empty <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (fifo_empty && (r_occ != '0)) r_occ <= '0;
            end
            S_WR: begin
               r_last_wr  <= r_data_in;
               r_err_full <= 1'b0;
               if (r_occ != CNT_W'(DEPTH)) r_occ <= r_occ + 1'b1;
            end
            S_RD: begin
               r_lat_cnt <= 1'b0;
            end
            S_RWAIT: begin
               r_lat_cnt <= r_lat_cnt + 1'b1;
               if (r_lat_cnt == LAT_LAST) begin
                  r_last_rd   <= fifo_data_out;
                  r_err_empty <= 1'b0;
                  if (r_occ != '0) r_occ <= r_occ - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign fifo_wr      = r_fifo_wr;
   assign fifo_rd      = r_fifo_rd;
   assign fifo_data_in = r_data_in;
   assign last_wr_data = r_last_wr;
   assign last_rd_data = r_last_rd;
   assign occupancy    = r_occ;
   assign busy         = (r_state != S_IDLE);
   assign err_full     = r_err_full;
   assign err_empty    = r_err_empty;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: small debounce window, behavioural FIFO model,
// expected strobe queue checked by a separate monitor, directed scenarios.
module tb_fifo_access_ctrl;

   localparam int DEB   = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = 5;

   localparam logic [1:0] K_WR = 2'b01;
   localparam logic [1:0] K_RD = 2'b10;

   logic             clk = 1'b0;
   logic             reset;
   logic             btn_wr;
   logic             btn_rd;
   logic [7:0]       sw_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_data_out;
   logic             fifo_wr;
   logic             fifo_rd;
   logic [7:0]       fifo_data_in;
   logic [7:0]       last_wr_data;
   logic [7:0]       last_rd_data;
   logic [CNT_W-1:0] occupancy;
   logic             busy;
   logic             err_full;
   logic             err_empty;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_err    = 0;

   logic [9:0] exp_q[$];
   logic [7:0] mem_q[$];
   logic [9:0] mon_e;

   fifo_access_ctrl #(
      .DEB_CYCLES(DEB), .DEPTH(DEPTH), .CNT_W(CNT_W), .RD_LAT(1)
   ) dut (
      .clk(clk), .reset(reset), .btn_wr(btn_wr), .btn_rd(btn_rd),
      .sw_data(sw_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
      .fifo_data_in(fifo_data_in), .last_wr_data(last_wr_data),
      .last_rd_data(last_rd_data), .occupancy(occupancy), .busy(busy),
      .err_full(err_full), .err_empty(err_empty), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Behavioural synchronous FIFO, read latency 1
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q.delete();
         fifo_full     <= 1'b0;
         fifo_empty    <= 1'b1;
         fifo_data_out <= 8'h00;
      end else begin
         if (fifo_wr && mem_q.size() < DEPTH) mem_q.push_back(fifo_data_in);
         if (fifo_rd && mem_q.size() > 0) fifo_data_out <= mem_q.pop_front();
         fifo_full  <= (mem_q.size() == DEPTH);
         fifo_empty <= (mem_q.size() == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one expectation per strobe
   always begin
      @(negedge clk);
      if (!reset) begin
         if (fifo_wr && fifo_rd) begin
            n_checks++;
            n_err++;
            $display("FAIL both_strobes: fifo_wr and fifo_rd high together");
         end
         if (fifo_wr || fifo_rd) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_strobe: got wr=%0b rd=%0b expected none", fifo_wr, fifo_rd);
            end else begin
               mon_e = exp_q.pop_front();
               check("strobe_kind", {30'd0, fifo_rd, fifo_wr}, {30'd0, mon_e[9:8]});
               if (fifo_wr) begin
                  check("wr_data", {24'd0, fifo_data_in}, {24'd0, mon_e[7:0]});
               end else begin
                  repeat (2) @(negedge clk);
                  check("rd_data", {24'd0, last_rd_data}, {24'd0, mon_e[7:0]});
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic press(input logic do_wr, input logic do_rd);
      @(negedge clk);
      btn_wr = do_wr;
      btn_rd = do_rd;
      repeat (DEB + 10) @(negedge clk);
      btn_wr = 1'b0;
      btn_rd = 1'b0;
      repeat (DEB + 10) @(negedge clk);
   endtask

   task automatic do_write(input logic [7:0] d);
      sw_data = d;
      exp_q.push_back({K_WR, d});
      press(1'b1, 1'b0);
   endtask

   task automatic do_read(input logic [7:0] d);
      exp_q.push_back({K_RD, d});
      press(1'b0, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr"},     {31'd0, fifo_wr},      32'd0);
      check({tag, "_rd"},     {31'd0, fifo_rd},      32'd0);
      check({tag, "_din"},    {24'd0, fifo_data_in}, 32'd0);
      check({tag, "_lastwr"}, {24'd0, last_wr_data}, 32'd0);
      check({tag, "_lastrd"}, {24'd0, last_rd_data}, 32'd0);
      check({tag, "_occ"},    {27'd0, occupancy},    32'd0);
      check({tag, "_busy"},   {31'd0, busy},         32'd0);
      check({tag, "_efull"},  {31'd0, err_full},     32'd0);
      check({tag, "_eempty"}, {31'd0, err_empty},    32'd0);
      check({tag, "_state"},  {30'd0, dbg_state},    32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      btn_wr  = 1'b0;
      btn_rd  = 1'b0;
      sw_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // T1: single write
      do_write(8'hA3);
      check("t1_lastwr", {24'd0, last_wr_data}, 32'hA3);
      check("t1_occ",    {27'd0, occupancy},    32'd1);
      check("t1_busy",   {31'd0, busy},         32'd0);

      // T3: read it back
      do_read(8'hA3);
      check("t3_lastrd", {24'd0, last_rd_data}, 32'hA3);
      check("t3_occ",    {27'd0, occupancy},    32'd0);
      check("t3_busy",   {31'd0, busy},         32'd0);

      // T2: bouncing write button gives exactly one write
      sw_data = 8'h5C;
      exp_q.push_back({K_WR, 8'h5C});
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         btn_wr = ~btn_wr;
         repeat (DEB / 2) @(negedge clk);
      end
      btn_wr = 1'b1;
      repeat (DEB + 10) @(negedge clk);
      btn_wr = 1'b0;
      repeat (DEB + 10) @(negedge clk);
      check("t2_lastwr", {24'd0, last_wr_data}, 32'h5C);
      check("t2_occ",    {27'd0, occupancy},    32'd1);
      do_read(8'h5C);

      // T4: read on empty is refused and sticky until a good read
      press(1'b0, 1'b1);
      check("t4_eempty", {31'd0, err_empty}, 32'd1);
      check("t4_occ0",   {27'd0, occupancy}, 32'd0);
      do_write(8'hB6);
      check("t4_eempty_hold", {31'd0, err_empty}, 32'd1);
      check("t4_occ1",        {27'd0, occupancy}, 32'd1);
      do_read(8'hB6);
      check("t4_eempty_clr", {31'd0, err_empty}, 32'd0);
      check("t4_occ_back",   {27'd0, occupancy}, 32'd0);

      // T5: fill to DEPTH, then a refused write
      for (int i = 0; i < DEPTH; i++) do_write(8'h10 + 8'(i));
      check("t5_occ_full", {27'd0, occupancy}, 32'd16);
      sw_data = 8'hFF;
      press(1'b1, 1'b0);
      check("t5_efull",    {31'd0, err_full},     32'd1);
      check("t5_occ_hold", {27'd0, occupancy},    32'd16);
      check("t5_lastwr",   {24'd0, last_wr_data}, 32'h1F);
      do_read(8'h10);
      do_read(8'h11);
      check("t5_occ14",    {27'd0, occupancy}, 32'd14);
      check("t5_efull_rd", {31'd0, err_full},  32'd1);

      // T6: simultaneous presses alternate priority
      sw_data = 8'hC1;
      exp_q.push_back({K_WR, 8'hC1});
      exp_q.push_back({K_RD, 8'h12});
      press(1'b1, 1'b1);
      check("t6a_occ",   {27'd0, occupancy},    32'd14);
      check("t6a_efull", {31'd0, err_full},     32'd0);
      check("t6a_lastwr", {24'd0, last_wr_data}, 32'hC1);
      sw_data = 8'hC2;
      exp_q.push_back({K_RD, 8'h13});
      exp_q.push_back({K_WR, 8'hC2});
      press(1'b1, 1'b1);
      check("t6b_occ",    {27'd0, occupancy},    32'd14);
      check("t6b_lastwr", {24'd0, last_wr_data}, 32'hC2);
      check("t6b_lastrd", {24'd0, last_rd_data}, 32'h13);

      // T6: reset during the read strobe
      @(negedge clk);
      btn_rd = 1'b1;
      begin
         int waited;
         waited = 0;
         do begin
            @(posedge clk);
            #1;
            waited++;
         end while (!fifo_rd && waited < 100);
         if (!fifo_rd) begin
            n_checks++;
            n_err++;
            $display("FAIL t6_rd_timeout: got no fifo_rd expected one within 100 cycles");
         end
      end
      reset = 1'b1;
      #1;
      check_all_zero("t6_reset");

      // Button held through reset: no request until pressed again
      @(negedge clk);
      reset = 1'b0;
      repeat (3 * DEB + 10) @(negedge clk);
      check("hold_eempty", {31'd0, err_empty}, 32'd0);
      check("hold_busy",   {31'd0, busy},      32'd0);
      btn_rd = 1'b0;
      repeat (DEB + 10) @(negedge clk);
      press(1'b0, 1'b1);
      check("repress_eempty", {31'd0, err_empty}, 32'd1);
      do_write(8'hC7);
      check("after_lastwr", {24'd0, last_wr_data}, 32'hC7);
      check("after_occ",    {27'd0, occupancy},    32'd1);

      repeat (5) @(negedge clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
